instr_stream_packer: RTL and testbench

INSTR_STREAM_PACKER -- requirements
Module: instr_stream_packer

---
 rtl/instr_stream_packer_pkg.sv | 28 ++
 rtl/instr_stream_packer.sv | 153 +++++++++++++++
 tb/tb_instr_stream_packer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/instr_stream_packer_pkg.sv
// Shared definitions for the instruction stream packer: window geometry,
// memory geometry, write-pointer reset value and the packer state encoding.
package instr_stream_packer_pkg;

    localparam int PKG_BYTE_W     = 8;
    localparam int PKG_WIN        = 4;
    localparam int PKG_LOG_WIN    = 2;
    localparam int PKG_ADDR_WIDTH = 8;
    localparam int PKG_DEPTH      = 256;
    localparam int PKG_WR_BASE    = 52;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_PEND = 2'd1,
        ST_DONE = 2'd2
    } pack_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/instr_stream_packer.sv
// Packs an upstream byte stream into WIN-byte windows and writes each window
// to the instruction memory controller once enough free space exists.
module instr_stream_packer
    import instr_stream_packer_pkg::*;
#(
    parameter int WIN        = PKG_WIN,
    parameter int LOG_WIN    = PKG_LOG_WIN,
    parameter int ADDR_WIDTH = PKG_ADDR_WIDTH,
    parameter int DEPTH      = PKG_DEPTH,
    parameter int WR_BASE    = PKG_WR_BASE
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      s_valid,
    input  logic [PKG_BYTE_W-1:0]     s_data,
    input  logic                      s_last,
    output logic                      s_ready,
    input  logic [ADDR_WIDTH-1:0]     read_pointer_out,
    output logic                      we,
    output logic [WIN*PKG_BYTE_W-1:0] wr_data,
    output logic [LOG_WIN-1:0]        write_pointer_shift_minusone,
    output logic                      load_done,
    output logic [15:0]               byte_count
);

    localparam int CNT_W  = LOG_WIN + 1;
    localparam int FREE_W = ADDR_WIDTH + 1;

    pack_state_e               state_r;
    pack_state_e               state_nxt_s;
    logic [CNT_W-1:0]          cnt_r;
    logic [WIN*PKG_BYTE_W-1:0] buf_r;
    logic                      last_r;
    logic [ADDR_WIDTH-1:0]     wr_ptr_r;
    logic [15:0]               byte_count_r;
    logic                      we_r;
    logic [WIN*PKG_BYTE_W-1:0] wr_data_r;
    logic [LOG_WIN-1:0]        shift_r;

    logic                      ready_s;
    logic                      accept_s;
    logic                      write_s;
    logic [ADDR_WIDTH-1:0]     occ_s;
    logic [FREE_W-1:0]         free_s;
    logic                      fits_s;

    // Free-space check against the consumer; occupancy wraps with the address width.
    always_comb begin
        occ_s  = wr_ptr_r - read_pointer_out;
        free_s = FREE_W'(DEPTH - 1) - FREE_W'(occ_s);
        fits_s = (free_s >= FREE_W'(cnt_r));
    end

    // Next-state, handshake and write-issue decode.
    always_comb begin
        state_nxt_s = state_r;
        ready_s     = 1'b0;
        write_s     = 1'b0;
        case (state_r)
            ST_FILL: begin
                ready_s = !rst;
                if (s_valid && ready_s && (s_last || (cnt_r == CNT_W'(WIN - 1)))) begin
                    state_nxt_s = ST_PEND;
                end else begin
                    state_nxt_s = ST_FILL;
                end
            end
            ST_PEND: begin
                if (fits_s) begin
                    write_s     = 1'b1;
                    state_nxt_s = last_r ? ST_DONE : ST_FILL;
                end else begin
                    state_nxt_s = ST_PEND;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_DONE;
            end
            default: begin
                state_nxt_s = ST_FILL;
            end
        endcase
        accept_s = s_valid && ready_s;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_FILL;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Window buffer, lane count and end-of-image flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r  <= '0;
            buf_r  <= '0;
            last_r <= 1'b0;
        end else if (write_s) begin
            cnt_r  <= '0;
            buf_r  <= '0;
            last_r <= 1'b0;
        end else if (accept_s) begin
            for (int i = 0; i < WIN; i++) begin
                if (cnt_r == CNT_W'(i)) begin
                    buf_r[i*PKG_BYTE_W +: PKG_BYTE_W] <= s_data;
                end
            end
            cnt_r  <= cnt_r + CNT_W'(1);
            last_r <= last_r | s_last;
        end
    end

    // Mirror of the controller's write pointer plus the saturating byte counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r     <= ADDR_WIDTH'(WR_BASE);
            byte_count_r <= 16'd0;
        end else begin
            if (write_s) begin
                wr_ptr_r <= wr_ptr_r + ADDR_WIDTH'(cnt_r);
            end
            if (accept_s) begin
                byte_count_r <= sat_inc16(byte_count_r);
            end
        end
    end

    // Registered write port; data is forced to zero whenever no strobe is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_r      <= 1'b0;
            wr_data_r <= '0;
            shift_r   <= '0;
        end else begin
            we_r      <= write_s;
            wr_data_r <= write_s ? buf_r : '0;
            if (write_s) begin
                shift_r <= LOG_WIN'(cnt_r - CNT_W'(1));
            end
        end
    end

    assign s_ready                      = ready_s;
    assign we                           = we_r;
    assign wr_data                      = wr_data_r;
    assign write_pointer_shift_minusone = shift_r;
    assign load_done                    = (state_r == ST_DONE);
    assign byte_count                   = byte_count_r;

endmodule

// File: tb/tb_instr_stream_packer.sv
// Directed bench for instr_stream_packer: window packing, back-pressure on a
// nearly full memory, reset discard and end-of-image behaviour.
module tb_instr_stream_packer;

    logic        clk;
    logic        rst;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_last;
    logic        s_ready;
    logic [7:0]  read_pointer_out;
    logic        we;
    logic [31:0] wr_data;
    logic [1:0]  write_pointer_shift_minusone;
    logic        load_done;
    logic [15:0] byte_count;

    int checks = 0;
    int errors = 0;
    logic        mon_en = 1'b0;
    logic [31:0] wq[$];
    logic [1:0]  sq[$];

    instr_stream_packer dut (
        .clk                          (clk),
        .rst                          (rst),
        .s_valid                      (s_valid),
        .s_data                       (s_data),
        .s_last                       (s_last),
        .s_ready                      (s_ready),
        .read_pointer_out             (read_pointer_out),
        .we                           (we),
        .wr_data                      (wr_data),
        .write_pointer_shift_minusone (write_pointer_shift_minusone),
        .load_done                    (load_done),
        .byte_count                   (byte_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Capture every write strobe; data must be zero whenever the strobe is low.
    always @(negedge clk) begin
        if (mon_en) begin
            if (we === 1'b1) begin
                wq.push_back(wr_data);
                sq.push_back(write_pointer_shift_minusone);
            end else begin
                chk("idle_data_zero", wr_data, 32'h0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        int n;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        n = 0;
        while (s_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("send_ready", {31'd0, s_ready}, 32'd1);
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        s_valid = 1'b0;
        s_data = 8'h00;
        s_last = 1'b0;
        read_pointer_out = 8'd52;

        // Reset values while reset is held.
        tick();
        chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
        chk("rst_we", {31'd0, we}, 32'd0);
        chk("rst_wr_data", wr_data, 32'h0);
        chk("rst_shift", {30'd0, write_pointer_shift_minusone}, 32'd0);
        chk("rst_load_done", {31'd0, load_done}, 32'd0);
        chk("rst_byte_count", {16'd0, byte_count}, 32'd0);
        rst = 1'b0;
        #1;
        chk("fill_s_ready", {31'd0, s_ready}, 32'd1);
        mon_en = 1'b1;

        // Eight bytes, last on 0x08: two full windows then done.
        for (int i = 1; i <= 8; i++) begin
            send_byte(8'(i), (i == 8));
        end
        tick();
        tick();
        chk("two_win_count", wq.size(), 32'd2);
        if (wq.size() == 2) begin
            chk("win0_data", wq[0], 32'h04030201);
            chk("win0_shift", {30'd0, sq[0]}, 32'd3);
            chk("win1_data", wq[1], 32'h08070605);
            chk("win1_shift", {30'd0, sq[1]}, 32'd3);
        end
        chk("eight_load_done", {31'd0, load_done}, 32'd1);
        chk("eight_byte_count", {16'd0, byte_count}, 32'd8);

        // Input held valid in DONE is ignored.
        s_valid = 1'b1;
        s_data  = 8'h55;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("done_s_ready", {31'd0, s_ready}, 32'd0);
        end
        s_valid = 1'b0;
        chk("done_byte_count", {16'd0, byte_count}, 32'd8);
        chk("done_no_we", wq.size(), 32'd2);
        chk("done_hold", {31'd0, load_done}, 32'd1);

        // Short final window of three bytes.
        do_reset();
        wq.delete();
        sq.delete();
        chk("reset_clears_done", {31'd0, load_done}, 32'd0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b1);
        tick();
        tick();
        chk("short_count", wq.size(), 32'd1);
        if (wq.size() == 1) begin
            chk("short_data", wq[0], 32'h00CCBBAA);
            chk("short_shift", {30'd0, sq[0]}, 32'd2);
        end
        chk("short_load_done", {31'd0, load_done}, 32'd1);
        chk("short_byte_count", {16'd0, byte_count}, 32'd3);

        // Partial window discarded by reset; stray s_last without valid ignored.
        // With the consumer at 57 only a pointer still at 52 leaves room for 4 bytes.
        do_reset();
        wq.delete();
        sq.delete();
        read_pointer_out = 8'd57;
        s_last = 1'b1;
        tick();
        tick();
        s_last = 1'b0;
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        do_reset();
        chk("discard_no_we", wq.size(), 32'd0);
        chk("discard_byte_count", {16'd0, byte_count}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            send_byte(8'h31 + 8'(i), 1'b0);
        end
        tick();
        tick();
        chk("after_rst_count", wq.size(), 32'd1);
        if (wq.size() == 1) begin
            chk("after_rst_data", wq[0], 32'h34333231);
            chk("after_rst_shift", {30'd0, sq[0]}, 32'd3);
        end
        chk("after_rst_not_done", {31'd0, load_done}, 32'd0);
        chk("after_rst_ready", {31'd0, s_ready}, 32'd1);

        // Fill memory to 252 bytes past the consumer, then hold a window for space.
        do_reset();
        wq.delete();
        sq.delete();
        read_pointer_out = 8'd52;
        for (int i = 0; i < 252; i++) begin
            send_byte(8'(i), 1'b0);
        end
        tick();
        tick();
        chk("bulk_count", wq.size(), 32'd63);
        if (wq.size() == 63) begin
            chk("bulk_last_data", wq[62], 32'hFBFAF9F8);
        end
        chk("bulk_byte_count", {16'd0, byte_count}, 32'd252);
        for (int i = 0; i < 4; i++) begin
            send_byte(8'hC1 + 8'(i), 1'b0);
        end
        for (int i = 0; i < 5; i++) begin
            chk("stall_we", {31'd0, we}, 32'd0);
            chk("stall_s_ready", {31'd0, s_ready}, 32'd0);
            tick();
        end
        chk("stall_no_write", wq.size(), 32'd63);
        read_pointer_out = 8'd53;
        tick();
        chk("release_we", {31'd0, we}, 32'd1);
        chk("release_data", wr_data, 32'hC4C3C2C1);
        chk("release_shift", {30'd0, write_pointer_shift_minusone}, 32'd3);
        tick();
        chk("release_one_pulse", {31'd0, we}, 32'd0);
        chk("release_ready", {31'd0, s_ready}, 32'd1);
        chk("release_byte_count", {16'd0, byte_count}, 32'd256);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
